tx_frame_arbiter: RTL and testbench
===================================

Name: tx_frame_arbiter

Overview:
- Shares the single UART transmitter between two response sources: command echo/ack and SAR/ramp result.
- Each granted request is serialized as a 3-byte frame: header, payload, checksum.
- Sequences the transmitter's start/din/eot handshake one byte at a time.
- Sits between the command FSM/measurement blocks and the transmitter's stt_i/din_i/eot_o ports.

Parameters:
- Nbits, 8, byte width of the transmitter data path.
- HeaderTag, 7'h55, upper 7 bits of the header byte; LSB carries the source id.
- NumBytes, 3, bytes per frame (fixed at 3; other values are not supported).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-high
- req_i  input  2  level request per source; requester holds high until its gnt_o pulse
- data0_i  input  Nbits  payload of source 0; sampled on grant
- data1_i  input  Nbits  payload of source 1; sampled on grant
- gnt_o  output  2  one-cycle grant pulse; payload latched
- done_o  output  2  one-cycle pulse when the granted source's frame has fully transmitted
- busy_o  output  1  high from grant until the cycle done_o is asserted, inclusive
- stt_o  output  1  one-cycle start pulse to transmitter stt_i
- din_o  output  Nbits  byte to transmitter din_i; valid while stt_o is high and held until the next load
- eot_i  input  1  end-of-transmission pulse from transmitter eot_o

Behaviour:
- All outputs are registered.
- Reset values: gnt_o=0, done_o=0, busy_o=0, stt_o=0, din_o=0, state=IDLE, byte index=0, rr pointer=0 (source 0 has priority).
- Reset is asynchronous at any time, including mid-frame. It aborts the frame with no done_o; the requester must re-request.
- States: IDLE, WAIT_EOT, DONE.
- IDLE, arbitration:
  - If exactly one req_i bit is set, that source wins.
  - If both are set, the source the rr pointer favors wins. The pointer favors the source NOT granted most recently; after reset it favors 0.
  - On the clock edge where IDLE sees a winner:
    - gnt_o[src]<=1, busy_o<=1.
    - Latch src and payload (data0_i or data1_i).
    - Compute header = {HeaderTag, src}.
    - stt_o<=1, din_o<=header, idx<=0, state<=WAIT_EOT.
  - Grant and first stt_o therefore appear in the same cycle, one cycle after req_i is seen in IDLE.
- WAIT_EOT:
  - stt_o and gnt_o are low after their single cycle.
  - din_o is held stable.
  - eot_i is awaited indefinitely; there is no timeout.
- On eot_i in WAIT_EOT:
  - idx=0: next edge stt_o<=1, din_o<=payload, idx<=1.
  - idx=1: next edge stt_o<=1, din_o<=header XOR payload, idx<=2.
  - idx=2: next edge done_o[src]<=1, state<=DONE, rr pointer<=~src.
- DONE (one cycle):
  - done_o is high and busy_o is still high.
  - Next edge: done_o<=0, busy_o<=0, state<=IDLE.
  - Earliest next grant is two cycles after the done_o cycle.
- eot_i in IDLE or DONE is ignored.
- req_i changes while busy are ignored. A request dropped before grant is simply not served.
- The payload is frozen at grant. Later data*_i changes do not affect the in-flight frame.
- Checksum uses the latched header and payload (bitwise XOR, Nbits wide).
- At most one gnt_o bit and one done_o bit is high at any time. gnt_o and done_o are never high in the same cycle.

Test Plan:
- Reset, then req_i=01 with data0_i=8'h3C. Expected:
  - gnt_o=01 and stt_o with din_o=8'hAA one cycle later.
  - After each model eot_i: din_o=8'h3C, then 8'h96.
  - After the third eot_i: done_o=01 for one cycle, busy_o falls the cycle after.
- req_i=10 with data1_i=8'hFF. Expected: header 8'hAB, payload 8'hFF, checksum 8'h54, then done_o=10.
- req_i=11 held continuously:
  - Grant order is 0, 1, 0, 1 across four frames.
  - A single request from source 1 right after reset wins immediately.
- Assert rst_i asynchronously between the second stt_o and its eot_i (mid-frame abort). Expected:
  - All outputs are 0 immediately; no done_o.
  - After reset, a re-request restarts with the header byte.
- Stray eot_i pulses in IDLE and DONE, and data0_i changed during the frame. Expected: no extra stt_o, and the frame bytes still reflect the payload latched at grant.
- Transmitter holds off eot_i for 10000 cycles. Expected: state stays in WAIT_EOT, din_o is stable, stt_o stays low, and the frame completes normally once eot_i arrives.

Source files
------------

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: shares one UART transmitter between two response sources,
// sending each grant as a header / payload / checksum frame.
`timescale 1ns/1ps
module tx_frame_arbiter #(
   parameter int unsigned      Nbits     = 8,
   parameter logic [Nbits-2:0] HeaderTag = 7'h55,
   parameter int unsigned      NumBytes  = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       req_i,
   input  logic [Nbits-1:0] data0_i,
   input  logic [Nbits-1:0] data1_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       done_o,
   output logic             busy_o,
   output logic             stt_o,
   output logic [Nbits-1:0] din_o,
   input  logic             eot_i
);

   localparam logic [1:0] LastIdx = 2'(NumBytes - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_EOT = 2'd1,
      S_DONE     = 2'd2
   } state_t;

   state_t           r_state;
   logic [1:0]       r_idx;
   logic             r_rr;
   logic             r_src;
   logic [Nbits-1:0] r_payload;
   logic [1:0]       r_gnt;
   logic [1:0]       r_done;
   logic             r_busy;
   logic             r_stt;
   logic [Nbits-1:0] r_din;

   logic             w_win_valid;
   logic             w_win_src;
   logic [Nbits-1:0] w_win_data;
   logic [Nbits-1:0] w_header;
   logic [Nbits-1:0] w_lat_header;

   // Arbitration: a lone requester wins; on contention the rr pointer decides.
   always_comb begin
      w_win_valid = |req_i;
      if (req_i == 2'b11) begin
         w_win_src = r_rr;
      end else begin
         w_win_src = req_i[1];
      end
      if (w_win_src) begin
         w_win_data = data1_i;
      end else begin
         w_win_data = data0_i;
      end
      w_header     = {HeaderTag, w_win_src};
      w_lat_header = {HeaderTag, r_src};
   end

   // Frame sequencer: grant, then one byte per transmitter eot, then a done cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_idx     <= 2'd0;
         r_rr      <= 1'b0;
         r_src     <= 1'b0;
         r_payload <= '0;
         r_gnt     <= 2'b00;
         r_done    <= 2'b00;
         r_busy    <= 1'b0;
         r_stt     <= 1'b0;
         r_din     <= '0;
      end else begin
         r_gnt  <= 2'b00;
         r_done <= 2'b00;
         r_stt  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_valid) begin
                  r_gnt     <= w_win_src ? 2'b10 : 2'b01;
                  r_busy    <= 1'b1;
                  r_src     <= w_win_src;
                  r_payload <= w_win_data;
                  r_stt     <= 1'b1;
                  r_din     <= w_header;
                  r_idx     <= 2'd0;
                  r_state   <= S_WAIT_EOT;
               end
            end
            S_WAIT_EOT: begin
               if (eot_i) begin
                  if (r_idx == LastIdx) begin
                     r_done  <= r_src ? 2'b10 : 2'b01;
                     r_rr    <= ~r_src;
                     r_state <= S_DONE;
                  end else begin
                     r_stt <= 1'b1;
                     r_idx <= r_idx + 2'd1;
                     if (r_idx == 2'd0) begin
                        r_din <= r_payload;
                     end else begin
                        r_din <= w_lat_header ^ r_payload;
                     end
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt_o  = r_gnt;
   assign done_o = r_done;
   assign busy_o = r_busy;
   assign stt_o  = r_stt;
   assign din_o  = r_din;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Self-checking bench for tx_frame_arbiter: directed frame table, corner sequences
// and randomized traffic against a byte-list reference model.
`timescale 1ns/1ps
module tb_tx_frame_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [7:0] d0, d1;
   logic       eot;
   logic [1:0] gnt_o, done_o;
   logic       busy_o, stt_o;
   logic [7:0] din_o;

   int checks = 0;
   int errors = 0;

   tx_frame_arbiter dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (req),
      .data0_i(d0),
      .data1_i(d1),
      .gnt_o  (gnt_o),
      .done_o (done_o),
      .busy_o (busy_o),
      .stt_o  (stt_o),
      .din_o  (din_o),
      .eot_i  (eot)
   );

   always #5 clk = ~clk;

   // Reference model: frame kept as a list of bytes still to be sent.
   int         m_busy, m_done_ph, m_src, m_next, m_last;
   logic [7:0] m_bytes[3];
   logic [7:0] m_din;
   logic [1:0] e_gnt, e_done;
   logic       e_stt, e_busy;

   typedef struct {
      logic [1:0] req;
      logic [7:0] d0, d1;
      logic [1:0] gnt;
      logic [7:0] hdr, pay, chk;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_done_ph = 0; m_last = 1; m_next = 0; m_src = 0;
      m_din = 8'h00; e_gnt = 2'b00; e_done = 2'b00; e_stt = 1'b0; e_busy = 1'b0;
   endtask

   task automatic model_clock(input logic [1:0] r, input logic e, input logic [7:0] a, input logic [7:0] b);
      e_gnt = 2'b00; e_done = 2'b00; e_stt = 1'b0;
      if (m_done_ph != 0) begin
         m_done_ph = 0; m_busy = 0;
      end else if (m_busy != 0) begin
         if (e) begin
            if (m_next < 3) begin
               e_stt = 1'b1; m_din = m_bytes[m_next]; m_next++;
            end else begin
               e_done = 2'(1 << m_src); m_done_ph = 1;
            end
         end
      end else if (r != 2'b00) begin
         m_src  = (r == 2'b11) ? 1 - m_last : (r == 2'b10 ? 1 : 0);
         m_last = m_src;
         m_bytes[0] = {7'h55, 1'(m_src)};
         m_bytes[1] = (m_src == 1) ? b : a;
         m_bytes[2] = m_bytes[0] ^ m_bytes[1];
         e_gnt = 2'(1 << m_src); e_stt = 1'b1; m_din = m_bytes[0]; m_next = 1; m_busy = 1;
      end
      e_busy = (m_busy != 0);
   endtask

   task automatic step(input logic [1:0] r, input logic e);
      logic [7:0] a, b;
      a = d0; b = d1;
      req = r; eot = e;
      @(posedge clk); #1;
      model_clock(r, e, a, b);
      check("cycle", {gnt_o, done_o, busy_o, stt_o, din_o}, {e_gnt, e_done, e_busy, e_stt, m_din});
   endtask

   task automatic run_frame(input vec_t v, input int gap);
      int n;
      d0 = v.d0; d1 = v.d1;
      n = 0;
      step(v.req, 1'b0);
      while (gnt_o == 2'b00 && n < 8) begin
         step(v.req, 1'b0); n++;
      end
      check("gnt", gnt_o, v.gnt);
      check("hdr", {stt_o, din_o}, {1'b1, v.hdr});
      d0 = ~v.d0; d1 = ~v.d1;
      repeat (gap) step(2'b00, 1'b0);
      step(2'b00, 1'b1);
      check("payload", {stt_o, din_o}, {1'b1, v.pay});
      repeat (gap) step(2'b00, 1'b0);
      step(2'b00, 1'b1);
      check("checksum", {stt_o, din_o}, {1'b1, v.chk});
      repeat (gap) step(2'b00, 1'b0);
      step(2'b00, 1'b1);
      check("done", {done_o, busy_o}, {v.gnt, 1'b1});
      step(2'b00, 1'b1);
      check("after_done", {done_o, busy_o, stt_o}, 3'b000);
   endtask

   initial begin
      logic [1:0] order[$];
      logic       eot_nx;
      logic [7:0] held;
      int         n;

      vecs[0] = '{2'b01, 8'h3C, 8'h00, 2'b01, 8'hAA, 8'h3C, 8'h96};
      vecs[1] = '{2'b10, 8'h00, 8'hFF, 2'b10, 8'hAB, 8'hFF, 8'h54};
      vecs[2] = '{2'b11, 8'h12, 8'h34, 2'b01, 8'hAA, 8'h12, 8'hB8};
      vecs[3] = '{2'b11, 8'h12, 8'h34, 2'b10, 8'hAB, 8'h34, 8'h9F};
      vecs[4] = '{2'b11, 8'hC3, 8'h5A, 2'b01, 8'hAA, 8'hC3, 8'h69};
      vecs[5] = '{2'b11, 8'hC3, 8'h5A, 2'b10, 8'hAB, 8'h5A, 8'hF1};

      rst = 1'b1; req = 2'b00; eot = 1'b0; d0 = 8'h00; d1 = 8'h00;
      model_reset();
      #12;
      check("reset", {gnt_o, done_o, busy_o, stt_o, din_o}, 14'h0);
      @(negedge clk); rst = 1'b0;

      // Stray eot in IDLE must not start anything.
      step(2'b00, 1'b1);
      step(2'b00, 1'b1);
      check("idle_eot", {stt_o, busy_o}, 2'b00);

      for (int i = 0; i < 6; i++) run_frame(vecs[i], i % 3);

      // Continuous 11 request: expect alternating grants 0,1,0,1.
      eot_nx = 1'b0; n = 0;
      while (order.size() < 4 && n < 80) begin
         step(2'b11, eot_nx);
         eot_nx = stt_o;
         if (gnt_o != 2'b00) order.push_back(gnt_o);
         n++;
      end
      check("rr_count", order.size(), 4);
      while (order.size() < 4) order.push_back(2'b00);
      check("rr_order", {order[0], order[1], order[2], order[3]}, 8'b01_10_01_10);
      repeat (6) step(2'b00, eot_nx);

      // Mid-frame asynchronous reset after the second stt.
      d0 = 8'h77;
      step(2'b01, 1'b0);
      step(2'b00, 1'b0);
      step(2'b00, 1'b1);
      check("mid_payload", {stt_o, din_o}, {1'b1, 8'h77});
      step(2'b00, 1'b0);
      #1 rst = 1'b1;
      #1 check("async_reset", {gnt_o, done_o, busy_o, stt_o, din_o}, 14'h0);
      model_reset();
      @(negedge clk);
      check("reset_hold", {done_o, busy_o}, 3'b000);
      rst = 1'b0;
      run_frame('{2'b10, 8'h01, 8'h42, 2'b10, 8'hAB, 8'h42, 8'hE9}, 0);
      run_frame('{2'b01, 8'h81, 8'h00, 2'b01, 8'hAA, 8'h81, 8'h2B}, 1);

      // Long eot hold-off: WAIT_EOT must keep din_o stable with no start.
      d0 = 8'h5E;
      step(2'b01, 1'b0);
      held = din_o;
      d0 = 8'hA1;
      n = 0;
      repeat (10000) begin
         step(2'b00, 1'b0);
         if (stt_o !== 1'b0 || din_o !== held || busy_o !== 1'b1) n++;
      end
      check("hold_off", n, 0);
      step(2'b00, 1'b1);
      check("hold_payload", din_o, 8'h5E);
      step(2'b00, 1'b1);
      check("hold_chk", din_o, 8'hAA ^ 8'h5E);
      step(2'b00, 1'b1);
      check("hold_done", done_o, 2'b01);
      step(2'b00, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
